// File: rtl/lcd_char_editor.sv
// lcd_char_editor: rotary-encoder driven character editor for a character LCD.
// A cursor walks over NUM_POSITIONS cells (MOVE mode), or the character under
// the cursor is stepped through CHAR_MIN..CHAR_MAX with wrap (EDIT mode).
// The display is blanked after reset and on clear_req.
//
// Optional build macro: LCD_EDITOR_AUTO_ADVANCE_EN
//   defined   -> down in EDIT returns to MOVE and advances the cursor by one
//   undefined -> down only toggles the mode
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | write BLANK_CHAR to every cell, one cell per cycle
// IDLE  | waiting for an input event; lcd_location follows the cursor
// READ  | holding lcd_location for RD_LATENCY cycles to fetch the cell
// WRITE | single write strobe with the stepped character
module lcd_char_editor #(
    parameter int         NUM_POSITIONS = 32,
    parameter int         LOC_W         = 5,
    parameter logic [7:0] CHAR_MIN      = 8'h20,
    parameter logic [7:0] CHAR_MAX      = 8'h7E,
    parameter logic [7:0] BLANK_CHAR    = 8'h20,
    parameter int         RD_LATENCY    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             right,
    input  logic             left,
    input  logic             down,
    input  logic             clear_req,
    input  logic [7:0]       lcd_rd_data,
    output logic             lcd_we,
    output logic [LOC_W-1:0] lcd_location,
    output logic [7:0]       lcd_data,
    output logic [LOC_W-1:0] cursor,
    output logic             edit_mode,
    output logic             busy
);

    typedef enum logic [1:0] {CLEAR, IDLE, READ, WRITE} stateType;

    localparam logic [LOC_W-1:0] LAST_POS = LOC_W'(NUM_POSITIONS - 1);
    // The clear index runs one past the last cell so the final write is
    // still shown while busy is high.
    localparam logic [LOC_W:0]   CLR_END  = (LOC_W+1)'(NUM_POSITIONS);
    localparam logic [1:0]       RD_LOAD  = 2'(RD_LATENCY - 1);

    stateType         state, stateNext;
    logic [LOC_W:0]   clrIdx, clrIdxNext;
    logic [1:0]       rdCnt, rdCntNext;
    logic             dirInc, dirIncNext;
    logic [LOC_W-1:0] cursorNext, cursorUp, cursorDown;
    logic             editMode, editModeNext;
    logic             weNext;
    logic [LOC_W-1:0] locNext;
    logic [7:0]       dataNext;
    logic             ackRight, ackLeft, ackDown, ackClear;
    logic             takeRight, takeLeft, takeDown, takeClear;

    function automatic logic [7:0] incChar(input logic [7:0] r);
        if (r >= CHAR_MAX || r < CHAR_MIN) return CHAR_MIN;
        return r + 8'd1;
    endfunction

    function automatic logic [7:0] decChar(input logic [7:0] r);
        if (r <= CHAR_MIN || r > CHAR_MAX) return CHAR_MAX;
        return r - 8'd1;
    endfunction

    assign cursorUp   = (cursor == LAST_POS) ? '0 : cursor + LOC_W'(1);
    assign cursorDown = (cursor == '0) ? LAST_POS : cursor - LOC_W'(1);

    assign edit_mode = editMode;
    assign busy      = (state != IDLE);

    // State, datapath and registered LCD outputs; reset aborts any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= CLEAR;
            clrIdx       <= '0;
            rdCnt        <= '0;
            dirInc       <= 1'b0;
            cursor       <= '0;
            editMode     <= 1'b0;
            lcd_we       <= 1'b0;
            lcd_location <= '0;
            lcd_data     <= '0;
        end else begin
            state        <= stateNext;
            clrIdx       <= clrIdxNext;
            rdCnt        <= rdCntNext;
            dirInc       <= dirIncNext;
            cursor       <= cursorNext;
            editMode     <= editModeNext;
            lcd_we       <= weNext;
            lcd_location <= locNext;
            lcd_data     <= dataNext;
        end
    end

    // Ack flags: set only by the event actually taken, released when the level drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ackRight <= 1'b0;
            ackLeft  <= 1'b0;
            ackDown  <= 1'b0;
            ackClear <= 1'b0;
        end else begin
            ackRight <= right & (ackRight | takeRight);
            ackLeft  <= left & (ackLeft | takeLeft);
            ackDown  <= down & (ackDown | takeDown);
            ackClear <= clear_req & (ackClear | takeClear);
        end
    end

    // Next-state, event arbitration and next LCD port values.
    always_comb begin
        stateNext    = state;
        clrIdxNext   = clrIdx;
        rdCntNext    = rdCnt;
        dirIncNext   = dirInc;
        cursorNext   = cursor;
        editModeNext = editMode;
        weNext       = 1'b0;
        locNext      = lcd_location;
        dataNext     = lcd_data;
        takeRight    = 1'b0;
        takeLeft     = 1'b0;
        takeDown     = 1'b0;
        takeClear    = 1'b0;

        case (state)
            CLEAR: begin
                if (clrIdx == CLR_END) begin
                    stateNext    = IDLE;
                    cursorNext   = '0;
                    editModeNext = 1'b0;
                    locNext      = '0;
                end else begin
                    weNext     = 1'b1;
                    locNext    = clrIdx[LOC_W-1:0];
                    dataNext   = BLANK_CHAR;
                    clrIdxNext = clrIdx + (LOC_W+1)'(1);
                end
            end
            IDLE: begin
                locNext = cursor;
                if (clear_req && !ackClear) begin
                    takeClear  = 1'b1;
                    stateNext  = CLEAR;
                    clrIdxNext = '0;
                end else if (right && !ackRight) begin
                    takeRight = 1'b1;
                    if (editMode) begin
                        dirIncNext = 1'b1;
                        rdCntNext  = RD_LOAD;
                        stateNext  = READ;
                    end else begin
                        cursorNext = cursorUp;
                        locNext    = cursorUp;
                    end
                end else if (left && !ackLeft) begin
                    takeLeft = 1'b1;
                    if (editMode) begin
                        dirIncNext = 1'b0;
                        rdCntNext  = RD_LOAD;
                        stateNext  = READ;
                    end else begin
                        cursorNext = cursorDown;
                        locNext    = cursorDown;
                    end
                end else if (down && !ackDown) begin
                    takeDown     = 1'b1;
                    editModeNext = !editMode;
`ifdef LCD_EDITOR_AUTO_ADVANCE_EN
                    if (editMode) begin
                        cursorNext = cursorUp;
                        locNext    = cursorUp;
                    end
`endif
                end
            end
            READ: begin
                if (rdCnt == '0) begin
                    stateNext = WRITE;
                    weNext    = 1'b1;
                    dataNext  = dirInc ? incChar(lcd_rd_data) : decChar(lcd_rd_data);
                end else begin
                    rdCntNext = rdCnt - 2'd1;
                end
            end
            WRITE: begin
                stateNext = IDLE;
                locNext   = cursor;
            end
            default: stateNext = CLEAR;
        endcase
    end

endmodule

// File: doc/lcd_char_editor.md
Name: lcd_char_editor

Overview:
- Parametrised rotary-encoder character editor for the character LCD.
- Consumes debounced right/left/down levels from the rotary interpreter and keeps a cursor over NUM_POSITIONS display cells.
- Has two modes. MOVE: rotation moves the cursor. EDIT: rotation steps the character under the cursor through a bounded range with wrap.
- Drives the LCD controller's write/location/data port, reads back the current cell, and clears the display on reset or on request.

Parameters:
- NUM_POSITIONS, 32, number of display cells; legal range 2..2**LOC_W.
- LOC_W, 5, width of location/cursor buses.
- CHAR_MIN, 8'h20, lowest editable character.
- CHAR_MAX, 8'h7E, highest editable character; must be greater than CHAR_MIN.
- BLANK_CHAR, 8'h20, character written during clear.
- RD_LATENCY, 1, cycles from lcd_location stable to lcd_rd_data valid; legal range 1..4.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- right  in  1  level from rotary interpreter, clockwise.
- left  in  1  level, counter-clockwise.
- down  in  1  level, button press.
- clear_req  in  1  one-cycle request to blank the display.
- lcd_rd_data  in  8  character at lcd_location, from LCD controller.
- lcd_we  out  1  write strobe, one cycle per write.
- lcd_location  out  LOC_W  cell address.
- lcd_data  out  8  character to write.
- cursor  out  LOC_W  current cursor cell.
- edit_mode  out  1  1 = EDIT, 0 = MOVE.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): lcd_we=0, lcd_location=0, lcd_data=0, cursor=0, edit_mode=0, busy=1, all ack flags cleared, state=CLEAR, clear index=0.
- Reset asserted mid-operation aborts immediately; no partial write completes.
- Event detect, per input: an event fires when the input=1, its ack=0, and state=IDLE; firing sets ack. Ack clears only when the input=0.
- Inputs held high while busy stay pending and are taken on return to IDLE.
- Simultaneous events priority: clear_req > right > left > down. Only one event is accepted per IDLE cycle.
- clear_req arriving while busy is dropped.
- States: CLEAR, IDLE, READ, WRITE.
- CLEAR: each cycle lcd_we=1, lcd_location=index, lcd_data=BLANK_CHAR, index++.
  - After writing index NUM_POSITIONS-1, next state is IDLE with cursor=0 and edit_mode=0.
  - Duration: exactly NUM_POSITIONS cycles of lcd_we.
- IDLE: lcd_we=0, lcd_location=cursor.
  - MOVE + right: cursor = (cursor==NUM_POSITIONS-1) ? 0 : cursor+1. Takes one cycle, no LCD access.
  - MOVE + left: cursor = (cursor==0) ? NUM_POSITIONS-1 : cursor-1.
  - down: toggles edit_mode, no LCD access.
  - EDIT + right/left: latch direction, go to READ.
- READ: hold lcd_location=cursor for RD_LATENCY cycles. Sample lcd_rd_data on the last cycle, then go to WRITE.
- Arithmetic, with r = sampled character:
  - inc: (r>=CHAR_MAX or r<CHAR_MIN) gives CHAR_MIN, else r+1.
  - dec: (r<=CHAR_MIN or r>CHAR_MAX) gives CHAR_MAX, else r-1.
  - All 8-bit, no carry out.
- WRITE: one cycle with lcd_we=1, lcd_location=cursor, lcd_data=result, then IDLE.
- Latency: an edit accepted in IDLE at cycle T writes at cycle T+RD_LATENCY+1. The next event can be accepted at T+RD_LATENCY+2.
- lcd_data holds its last value when lcd_we=0.

Optional Feature:
- Macro: LCD_EDITOR_AUTO_ADVANCE_EN.
- Defined: down in EDIT mode switches to MOVE and also advances cursor by one with wrap (NUM_POSITIONS-1 → 0).
- Undefined: down only toggles mode; cursor unchanged.
- down in MOVE mode behaves identically either way.

Test Plan:
- Release rst with defaults → 32 consecutive lcd_we pulses at locations 0..31 with data 8'h20, then busy=0, cursor=0, edit_mode=0.
- MOVE mode, cursor=31, right pulse → cursor=0, no lcd_we. Then left pulse → cursor=31.
- down, then right with lcd_rd_data=8'h41, RD_LATENCY=1 → accepted at T, lcd_we at T+2 with lcd_data=8'h42, location=cursor.
- EDIT mode, lcd_rd_data=8'h7E, right → writes 8'h20. lcd_rd_data=8'h20, left → writes 8'h7E. lcd_rd_data=8'h05, right → writes 8'h20.
- right and left rise in the same cycle while in EDIT → only increment performed. right held high for 10 cycles → exactly one write. left still high after the write → decrement follows.
- Assert rst during READ → outputs return to reset values immediately, CLEAR sequence restarts. With LCD_EDITOR_AUTO_ADVANCE_EN, cursor=4 in EDIT, down → edit_mode=0, cursor=5.
